// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks the highest-priority event on a valid,
// unstalled instruction, reports it to cp0_reg and redirects with a flush pulse.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_addr_i,
  input  logic [8:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] pc_o,
  output logic [31:0] bad_vaddr_o,
  output logic        is_in_delayslot_o,
  output logic        mem_kill_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_q;
  logic        int_pend_q;
  logic [31:0] new_pc_q;

  logic        int_req;
  logic        accept;
  logic        is_eret;
  logic [4:0]  code;
  logic [31:0] bad_vaddr;

  // Status/Cause bits outside the IM/IP, IE and EXL fields are not consulted.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign int_req = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
                 & cp0_status_i[0] & ~cp0_status_i[1];

  // rst gates acceptance so every output drops the moment reset rises.
  assign accept = ~rst & (state_q == IDLE) & mem_valid_i & ~stall_i
                & (int_pend_q | (|mem_exc_i));

  always_comb begin
    code      = 5'h00;
    bad_vaddr = 32'd0;
    is_eret   = 1'b0;
    if (int_pend_q) begin
      code = 5'h01;
    end else if (mem_exc_i[0]) begin
      code      = 5'h04;
      bad_vaddr = mem_pc_i;
    end else if (mem_exc_i[1]) begin
      code = 5'h0A;
    end else if (mem_exc_i[2]) begin
      code = 5'h0C;
    end else if (mem_exc_i[3]) begin
      code = 5'h0D;
    end else if (mem_exc_i[4]) begin
      code = 5'h08;
    end else if (mem_exc_i[5]) begin
      code = 5'h09;
    end else if (mem_exc_i[6]) begin
      code      = 5'h04;
      bad_vaddr = mem_addr_i;
    end else if (mem_exc_i[7]) begin
      code      = 5'h05;
      bad_vaddr = mem_addr_i;
    end else if (mem_exc_i[8]) begin
      code    = 5'h0E;
      is_eret = 1'b1;
    end
  end

  assign excepttype_o      = accept ? {27'd0, code} : 32'd0;
  assign pc_o              = accept ? mem_pc_i : 32'd0;
  assign bad_vaddr_o       = accept ? bad_vaddr : 32'd0;
  assign is_in_delayslot_o = accept & mem_in_ds_i;
  assign mem_kill_o        = accept;

  assign flush_o  = ~rst & (state_q == FLUSH);
  assign new_pc_o = flush_o ? new_pc_q : 32'd0;

  // The pending interrupt is wiped during FLUSH so it cannot be taken twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      int_pend_q <= 1'b0;
      new_pc_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          int_pend_q <= int_req;
          if (accept) begin
            state_q  <= FLUSH;
            new_pc_q <= is_eret ? cp0_epc_i : EXC_VECTOR;
          end
        end
        FLUSH: begin
          int_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          int_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed vector table, hand sequences for stall,
// back-to-back and async reset, then randomized traffic against a reference model.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, mem_valid_i, mem_in_ds_i;
  logic [31:0] mem_pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic [8:0]  mem_exc_i;
  logic [31:0] excepttype_o, pc_o, bad_vaddr_o, new_pc_o;
  logic        is_in_delayslot_o, mem_kill_o, flush_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  except_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
    .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i), .mem_addr_i(mem_addr_i),
    .mem_exc_i(mem_exc_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .excepttype_o(excepttype_o), .pc_o(pc_o),
    .bad_vaddr_o(bad_vaddr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .mem_kill_o(mem_kill_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irq;
    logic [8:0]  exc;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] epc;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[12];
  logic [4:0] exc_code[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_irq(input logic on);
    cp0_status_i = 32'h0000_FF01;
    cp0_cause_i  = on ? 32'h0000_0400 : 32'd0;
  endtask

  task automatic go_quiet();
    mem_valid_i = 1'b0;
    mem_exc_i   = 9'd0;
    stall_i     = 1'b0;
  endtask

  task automatic chk_no_event(input string tag);
    chk({tag, "_type"}, excepttype_o, 32'd0);
    chk({tag, "_kill"}, {31'd0, mem_kill_o}, 32'd0);
    chk({tag, "_bad"}, bad_vaddr_o, 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
  endtask

  function automatic logic int_req_of(input logic [31:0] st, input logic [31:0] ca);
    logic [7:0] hit;
    hit = st[15:8] & ca[15:8];
    return (hit != 8'd0) && st[0] && !st[1];
  endfunction

  // Reference model state: whether this cycle is a flush cycle, and the sampled interrupt.
  logic m_flush, m_pend;

  initial begin
    exc_code = '{5'h04, 5'h0A, 5'h0C, 5'h0D, 5'h08, 5'h09, 5'h04, 5'h05, 5'h0E};
    //            irq   exc      pc            addr          epc           code   bad           npc
    vecs[0]  = '{1'b0, 9'h010, 32'hBFC00100, 32'h0,        32'h0,        5'h08, 32'h0,        VEC};
    vecs[1]  = '{1'b0, 9'h100, 32'h80000200, 32'h0,        32'h80001000, 5'h0E, 32'h0,        32'h80001000};
    vecs[2]  = '{1'b1, 9'h084, 32'h00400000, 32'h00001003, 32'h0,        5'h01, 32'h0,        VEC};
    vecs[3]  = '{1'b0, 9'h084, 32'h00400004, 32'h00001003, 32'h0,        5'h0C, 32'h0,        VEC};
    vecs[4]  = '{1'b0, 9'h080, 32'h00400008, 32'h00001003, 32'h0,        5'h05, 32'h00001003, VEC};
    vecs[5]  = '{1'b0, 9'h040, 32'h0040000C, 32'h00002001, 32'h0,        5'h04, 32'h00002001, VEC};
    vecs[6]  = '{1'b0, 9'h003, 32'h00000003, 32'h00005000, 32'h0,        5'h04, 32'h00000003, VEC};
    vecs[7]  = '{1'b0, 9'h060, 32'h00400010, 32'h00003002, 32'h0,        5'h09, 32'h0,        VEC};
    vecs[8]  = '{1'b0, 9'h018, 32'h00400014, 32'h0,        32'h0,        5'h0D, 32'h0,        VEC};
    vecs[9]  = '{1'b0, 9'h002, 32'h00400018, 32'h0,        32'h0,        5'h0A, 32'h0,        VEC};
    vecs[10] = '{1'b1, 9'h100, 32'h0040001C, 32'h0,        32'h80001000, 5'h01, 32'h0,        VEC};
    vecs[11] = '{1'b0, 9'h000, 32'h00400020, 32'h0,        32'h0,        5'h00, 32'h0,        32'h0};

    // Reset with an event on the inputs: outputs must be zero before any edge.
    rst = 1'b1;
    set_irq(1'b1);
    mem_valid_i = 1'b1; mem_exc_i = 9'h010; stall_i = 1'b0;
    mem_pc_i = 32'h1234; mem_addr_i = 32'h5678; mem_in_ds_i = 1'b1; cp0_epc_i = 32'h0;
    #3;
    chk_no_event("reset");
    chk("reset_flush", {31'd0, flush_o}, 32'd0);
    chk("reset_newpc", new_pc_o, 32'd0);
    chk("reset_ds", {31'd0, is_in_delayslot_o}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    mem_exc_i = 9'd0; mem_in_ds_i = 1'b0;
    #2;
    chk("post_rst_no_irq_yet", excepttype_o, 32'd0);
    tick();
    #4;
    chk("post_rst_irq_type", excepttype_o, 32'h01);
    chk("post_rst_irq_pc", pc_o, 32'h1234);
    tick();
    go_quiet(); set_irq(1'b0);
    #4;
    chk("post_rst_flush", {31'd0, flush_o}, 32'd1);
    chk("post_rst_newpc", new_pc_o, VEC);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      tick();
      go_quiet();
      set_irq(vecs[i].irq);
      tick();
      mem_valid_i = 1'b1;
      mem_exc_i   = vecs[i].exc;
      mem_pc_i    = vecs[i].pc;
      mem_addr_i  = vecs[i].addr;
      cp0_epc_i   = vecs[i].epc;
      mem_in_ds_i = i[0];
      #4;
      chk($sformatf("v%0d_type", i), excepttype_o, {27'd0, vecs[i].code});
      chk($sformatf("v%0d_bad", i), bad_vaddr_o, vecs[i].bad);
      chk($sformatf("v%0d_kill", i), {31'd0, mem_kill_o}, {31'd0, vecs[i].code != 5'd0});
      chk($sformatf("v%0d_pc", i), pc_o, (vecs[i].code != 5'd0) ? vecs[i].pc : 32'd0);
      chk($sformatf("v%0d_ds", i), {31'd0, is_in_delayslot_o},
          {31'd0, (vecs[i].code != 5'd0) && i[0]});
      tick();
      go_quiet();
      #4;
      chk($sformatf("v%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].code != 5'd0});
      chk($sformatf("v%0d_newpc", i), new_pc_o, vecs[i].npc);
    end

    // Stalled adel_if: nothing while held, accepted on release.
    tick();
    set_irq(1'b0);
    mem_valid_i = 1'b1; mem_exc_i = 9'h001; mem_pc_i = 32'h00000102; stall_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #4;
      chk_no_event($sformatf("stall%0d", s));
      tick();
    end
    stall_i = 1'b0;
    #4;
    chk("stall_rel_type", excepttype_o, 32'h04);
    chk("stall_rel_bad", bad_vaddr_o, 32'h00000102);
    chk("stall_rel_kill", {31'd0, mem_kill_o}, 32'd1);
    tick();
    go_quiet();
    #4;
    chk("stall_flush", {31'd0, flush_o}, 32'd1);

    // Back-to-back: event held through the flush cycle is taken again after it.
    tick();
    mem_valid_i = 1'b1; mem_exc_i = 9'h020; mem_pc_i = 32'h00400100;
    #4;
    chk("b2b_t_type", excepttype_o, 32'h09);
    tick();
    #4;
    chk("b2b_t1_flush", {31'd0, flush_o}, 32'd1);
    chk("b2b_t1_type", excepttype_o, 32'd0);
    chk("b2b_t1_kill", {31'd0, mem_kill_o}, 32'd0);
    tick();
    #4;
    chk("b2b_t2_type", excepttype_o, 32'h09);
    chk("b2b_t2_flush", {31'd0, flush_o}, 32'd0);
    tick();
    go_quiet();
    #4;
    chk("b2b_t3_flush", {31'd0, flush_o}, 32'd1);
    chk("b2b_t3_newpc", new_pc_o, VEC);

    // Reset asserted part-way through a flush cycle.
    tick();
    mem_valid_i = 1'b1; mem_exc_i = 9'h010;
    #4;
    chk("arst_accept", {31'd0, mem_kill_o}, 32'd1);
    tick();
    go_quiet();
    chk("arst_flush_before", {31'd0, flush_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_flush_drop", {31'd0, flush_o}, 32'd0);
    chk("arst_newpc_drop", new_pc_o, 32'd0);
    tick();
    #2;
    rst = 1'b0;
    #2;
    chk("arst_idle_flush", {31'd0, flush_o}, 32'd0);
    tick();
    mem_valid_i = 1'b1; mem_exc_i = 9'h010;
    #4;
    chk("arst_idle_accept", excepttype_o, 32'h08);
    tick();
    go_quiet();
    #4;
    chk("arst_flush_again", {31'd0, flush_o}, 32'd1);

    // Randomized traffic against the reference model.
    tick();
    set_irq(1'b0);
    tick();
    tick();
    m_flush = 1'b0;
    m_pend  = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 2000; n++) begin
      logic        acc;
      logic [4:0]  e_code;
      logic [31:0] e_bad, e_npc;
      logic        ireq;
      tick();
      mem_valid_i  = ($urandom_range(0, 3) != 0);
      stall_i      = ($urandom_range(0, 3) == 0);
      mem_exc_i    = ($urandom_range(0, 2) == 0) ? 9'($urandom) :
                     ($urandom_range(0, 1) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'd0;
      mem_pc_i     = $urandom;
      mem_addr_i   = $urandom;
      mem_in_ds_i  = $urandom_range(0, 1);
      cp0_epc_i    = $urandom;
      cp0_status_i = {16'($urandom), 8'($urandom), 6'($urandom),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      cp0_cause_i  = {16'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0,
                      8'($urandom)};
      #4;
      acc    = !m_flush && mem_valid_i && !stall_i && (m_pend || mem_exc_i != 9'd0);
      e_code = 5'd0;
      e_bad  = 32'd0;
      e_npc  = VEC;
      if (acc) begin
        if (m_pend) begin
          e_code = 5'h01;
        end else begin
          for (int b = 8; b >= 0; b--) begin
            if (mem_exc_i[b]) begin
              e_code = exc_code[b];
              e_bad  = (b == 0) ? mem_pc_i : (b == 6 || b == 7) ? mem_addr_i : 32'd0;
              e_npc  = (b == 8) ? cp0_epc_i : VEC;
            end
          end
        end
      end
      chk("rnd_type", excepttype_o, {27'd0, e_code});
      chk("rnd_bad", bad_vaddr_o, e_bad);
      chk("rnd_pc", pc_o, acc ? mem_pc_i : 32'd0);
      chk("rnd_ds", {31'd0, is_in_delayslot_o}, {31'd0, acc && mem_in_ds_i});
      chk("rnd_kill", {31'd0, mem_kill_o}, {31'd0, acc});
      chk("rnd_flush", {31'd0, flush_o}, {31'd0, m_flush});
      if (m_flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_newpc: got %h expected <queue empty>", new_pc_o);
        end else begin
          chk("rnd_newpc", new_pc_o, exp_q.pop_front());
        end
      end else begin
        chk("rnd_newpc_idle", new_pc_o, 32'd0);
      end
      if (acc) exp_q.push_back(e_npc);
      ireq    = int_req_of(cp0_status_i, cp0_cause_i);
      m_pend  = m_flush ? 1'b0 : ireq;
      m_flush = acc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
